// File: rtl/sine_pkg.sv
// Shared types and helpers for the sine-wave sample sequencer.
package sine_pkg;

    // Sequencer states: idle, wait for tick, ROM read, capture, hold for handshake
    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead,
        StCapt,
        StHold
    } state_e;

    // ROM address width for a given depth (at least one bit)
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sine_tick_div.sv
// Sample-rate divider: counts 0..div and pulses tick on the terminal count.
// Held at zero while clear is high so the first tick lands div+1 cycles later.
module sine_tick_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = !clear && (cnt_q == div);

    // Wrap on tick, park at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sine_rom_sequencer.sv
// Phase accumulator and sample sequencer for the synchronous sine ROM.
// One ROM read per sample tick, absorbs the 1-cycle ROM latency and presents
// the sample on a valid/ready stream. Sticky overrun flags dropped ticks.
// Optional: define QUARTER_WAVE_EN for a quarter-cycle ROM with mirrored
// addressing and sign restoration.
module sine_rom_sequencer
    import sine_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DIV_W   = 16,
    localparam int unsigned AW     = addr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [DIV_W-1:0]   div,
    output logic               rom_en,
    output logic [AW-1:0]      rom_addr,
    input  logic [WIDTH-1:0]   rom_data,
    output logic [WIDTH-1:0]   sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic               overrun
);

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] tw_q;
    logic [DIV_W-1:0]   div_q;
    logic               stop_pend_q;
    logic               tick;
    logic               stop_now;
    logic [AW-1:0]      rd_addr;
`ifdef QUARTER_WAVE_EN
    logic [AW-1:0]      rd_idx;
    logic               rd_neg;
    logic               neg_q;
`endif

    sine_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == StIdle),
        .div   (div_q),
        .tick  (tick)
    );

    assign stop_now = stop || stop_pend_q;

    // ROM address (and sign in quarter-wave mode) for the current phase
    always_comb begin
`ifdef QUARTER_WAVE_EN
        rd_idx  = phase_q[PHASE_W-3 -: AW];
        // Odd quadrants walk the table backwards: DEPTH-1-i == ~i for power-of-two DEPTH
        rd_addr = phase_q[PHASE_W-2] ? ~rd_idx : rd_idx;
        rd_neg  = phase_q[PHASE_W-1];
`else
        rd_addr = phase_q[PHASE_W-1 -: AW];
`endif
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            tw_q         <= '0;
            div_q        <= '0;
            stop_pend_q  <= 1'b0;
            rom_en       <= 1'b0;
            rom_addr     <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef QUARTER_WAVE_EN
            neg_q        <= 1'b0;
`endif
        end else begin
            rom_en <= 1'b0;

            // A tick while a sample is in flight is dropped, but phase keeps time
            if (tick && (state_q inside {StRead, StCapt, StHold})) begin
                overrun <= 1'b1;
                phase_q <= phase_q + tw_q;
            end
            if (stop && (state_q != StIdle)) begin
                stop_pend_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_q     <= StWait;
                        tw_q        <= tuning_word;
                        div_q       <= div;
                        phase_q     <= '0;
                        overrun     <= 1'b0;
                        stop_pend_q <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                StWait: begin
                    if (stop_now) begin
                        state_q     <= StIdle;
                        stop_pend_q <= 1'b0;
                        busy        <= 1'b0;
                    end else if (tick) begin
                        state_q  <= StRead;
                        rom_en   <= 1'b1;
                        rom_addr <= rd_addr;
                        phase_q  <= phase_q + tw_q;
`ifdef QUARTER_WAVE_EN
                        neg_q    <= rd_neg;
`endif
                    end
                end
                StRead: begin
                    state_q <= StCapt;
                end
                StCapt: begin
`ifdef QUARTER_WAVE_EN
                    sample_data <= neg_q ? (WIDTH'(0) - rom_data) : rom_data;
`else
                    sample_data <= rom_data;
`endif
                    sample_valid <= 1'b1;
                    state_q      <= StHold;
                end
                StHold: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (stop_now) begin
                            state_q     <= StIdle;
                            stop_pend_q <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// Bench for sine_rom_sequencer: randomised runs checked cycle by cycle against a
// timing model built from tick times, read latency and handshake cycles.
module tb_sine_rom_sequencer;

    localparam int WIDTH   = 64;
    localparam int DEPTH   = 64;
    localparam int PHASE_W = 32;
    localparam int DIV_W   = 16;
    localparam int AW      = 6;
    localparam int NMAX    = 1100;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [PHASE_W-1:0] tuning_word = '0;
    logic [DIV_W-1:0]   div = '0;
    logic               rom_en;
    logic [AW-1:0]      rom_addr;
    logic [WIDTH-1:0]   rom_data = '0;
    logic [WIDTH-1:0]   sample_data;
    logic               sample_valid;
    logic               sample_ready = 1'b0;
    logic               busy;
    logic               overrun;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    bit               rdy   [NMAX];
    bit               e_en  [NMAX];
    logic [AW-1:0]    e_addr[NMAX];
    bit               e_val [NMAX];
    logic [WIDTH-1:0] e_dat [NMAX];
    bit               e_ovr [NMAX];

    sine_rom_sequencer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PHASE_W (PHASE_W),
        .DIV_W   (DIV_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .tuning_word  (tuning_word),
        .div          (div),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input logic [31:0] ph);
        logic [AW-1:0] i;
`ifdef QUARTER_WAVE_EN
        i = ph[29:24];
        return ph[30] ? AW'(DEPTH - 1 - int'(i)) : i;
`else
        i = ph[31:26];
        return i;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] data_of(input logic [31:0] ph);
        logic [WIDTH-1:0] d;
        d = mem[addr_of(ph)];
`ifdef QUARTER_WAVE_EN
        if (ph[31]) d = -d;
`endif
        return d;
    endfunction

    // Tick j happens in cycle 1+div+j*(div+1), start being cycle 0. A tick reads
    // only once the previous sample is accepted; any other tick is an overrun.
    task automatic build_model(input logic [31:0] tw, input int dv, input int n);
        int free_from;
        int ovr_from;
        int t;
        int a;
        logic [31:0] ph;
        free_from = 1;
        ovr_from  = NMAX;
        for (int c = 0; c < NMAX; c++) begin
            e_en[c] = 0; e_addr[c] = '0; e_val[c] = 0; e_dat[c] = '0; e_ovr[c] = 0;
        end
        for (int j = 0; j < NMAX; j++) begin
            t = 1 + dv + j * (dv + 1);
            if (t >= n) break;
            ph = 32'(j) * tw;
            if (t >= free_from) begin
                a = t + 3;
                while (a < n && !rdy[a]) a++;
                e_en[t+1]   = 1;
                e_addr[t+1] = addr_of(ph);
                for (int c = t + 3; c <= a && c < NMAX; c++) begin
                    e_val[c] = 1;
                    e_dat[c] = data_of(ph);
                end
                free_from = a + 1;
            end else if (ovr_from == NMAX) begin
                ovr_from = t + 1;
            end
        end
        for (int c = 0; c < NMAX; c++) e_ovr[c] = (c >= ovr_from);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_en"}, WIDTH'(rom_en), '0);
        check({tag, "_rom_addr"}, WIDTH'(rom_addr), '0);
        check({tag, "_sample_data"}, sample_data, '0);
        check({tag, "_sample_valid"}, WIDTH'(sample_valid), '0);
        check({tag, "_busy"}, WIDTH'(busy), '0);
        check({tag, "_overrun"}, WIDTH'(overrun), '0);
    endtask

    // One randomised run: start at cycle 0, scramble inputs while busy, then park
    // a sample in HOLD and reset asynchronously.
    task automatic run(input string name, input logic [31:0] tw, input int dv, input int n);
        int k;
        build_model(tw, dv, n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start        = (c == 0) ? 1'b1 : ($urandom_range(7) == 0);
            tuning_word  = (c == 0) ? tw : $urandom;
            div          = (c == 0) ? DIV_W'(dv) : DIV_W'($urandom_range(15));
            sample_ready = rdy[c];
            @(negedge clk);
            check($sformatf("%s_busy_c%0d", name, c), WIDTH'(busy), WIDTH'(c != 0));
            check($sformatf("%s_rom_en_c%0d", name, c), WIDTH'(rom_en), WIDTH'(e_en[c]));
            if (e_en[c])
                check($sformatf("%s_rom_addr_c%0d", name, c), WIDTH'(rom_addr),
                      WIDTH'(e_addr[c]));
            check($sformatf("%s_valid_c%0d", name, c), WIDTH'(sample_valid), WIDTH'(e_val[c]));
            if (e_val[c])
                check($sformatf("%s_data_c%0d", name, c), sample_data, e_dat[c]);
            check($sformatf("%s_overrun_c%0d", name, c), WIDTH'(overrun), WIDTH'(e_ovr[c]));
        end
        @(posedge clk); #1;
        start = 1'b0;
        sample_ready = 1'b0;
        k = 0;
        while (k < 40 && !sample_valid) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_park_in_hold"}, WIDTH'(sample_valid), WIDTH'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs({name, "_reset_mid_hold"});
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};

        // Power-on reset
        #2;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Full sweep: one table step per sample, no dropped ticks at div=3
        for (int c = 0; c < NMAX; c++) rdy[c] = 1;
        run("sweep", 32'h0400_0000, 3, 280);

        // Slow rate, always ready: one read per 10 cycles, no overrun
        run("div9", $urandom, 9, 200);

        // Downstream stalls for 25 cycles while a sample is held
        for (int c = 0; c < NMAX; c++) rdy[c] = !(c >= 22 && c < 47);
        run("stall", 32'h0400_0000, 9, 120);

        // div=0: tick every cycle, phase moves on dropped ticks too
        for (int c = 0; c < NMAX; c++) rdy[c] = 1;
        run("div0", 32'h0400_0000, 0, 100);

        // Random rates and random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NMAX; c++) rdy[c] = ($urandom_range(99) < 60);
            run($sformatf("rand%0d", r), $urandom, $urandom_range(5), 200);
        end

        // Fine step over a whole cycle (quadrant mirroring when enabled)
        for (int c = 0; c < NMAX; c++) rdy[c] = 1;
        run("fine", 32'h0100_0000, 3, 1040);

        // Directed stop/start sequence, tw step 1, div=9, ready high
        tuning_word  = 32'h0400_0000;
        div          = DIV_W'(9);
        sample_ready = 1'b1;
        for (int c = 0; c < 27; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 15) || (c == 21);
            stop  = (c == 12) || (c == 15) || (c == 23);
            @(negedge clk);
            if (c == 11) check("stop_read_en", WIDTH'(rom_en), WIDTH'(1));
            if (c == 12) check("stop_capt_valid", WIDTH'(sample_valid), WIDTH'(0));
            if (c == 13) check("stop_hold_valid", WIDTH'(sample_valid), WIDTH'(1));
            if (c == 13) check("stop_hold_data", sample_data, mem[0]);
            if (c == 13) check("stop_hold_busy", WIDTH'(busy), WIDTH'(1));
            if (c == 14) check("stop_idle_busy", WIDTH'(busy), WIDTH'(0));
            if (c == 14) check("stop_idle_valid", WIDTH'(sample_valid), WIDTH'(0));
            if (c >= 16 && c <= 21)
                check($sformatf("startstop_idle_busy_c%0d", c), WIDTH'(busy), WIDTH'(0));
            if (c >= 16)
                check($sformatf("no_read_c%0d", c), WIDTH'(rom_en), WIDTH'(0));
            if (c == 22 || c == 23)
                check($sformatf("wait_busy_c%0d", c), WIDTH'(busy), WIDTH'(1));
            if (c >= 24)
                check($sformatf("stop_wait_busy_c%0d", c), WIDTH'(busy), WIDTH'(0));
        end
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
